// File: rtl/frame_ram_reader_if.sv
// Pixel stream from the frame reader to its downstream consumer.
// The master drives data/valid/last and the slave returns ready.
interface frame_ram_reader_if #(
  parameter int NB_DATA = 12
);
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;

  modport master (
    output o_data,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/frame_ram_reader.sv
// Scans one frame out of the sensor controller's pixel RAM through its debug
// port. Each pixel is emitted as one valid/ready beat. Pixels strictly above
// a threshold are counted along the way.
module frame_ram_reader #(
  parameter  int COLS       = 24,
  parameter  int ROWS       = 24,
  parameter  int NB_DATA    = 12,
  parameter  int RD_LATENCY = 2,
  localparam int N_PIX      = COLS * ROWS,
  localparam int NB_ADDR    = $clog2(N_PIX),
  localparam int NB_CNT     = $clog2(N_PIX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_DATA-1:0]  i_umbral,
  input  logic [NB_DATA-1:0]  i_ram_data,
  output logic                o_ram_dbg,
  output logic [NB_ADDR-1:0]  o_ram_addr,
  frame_ram_reader_if.master  strm,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_CNT-1:0]   o_above_cnt
);

  // The latency counter only needs to reach RD_LATENCY-1 (at most 14).
  localparam int               NB_LAT    = 4;
  localparam logic [NB_LAT-1:0]  LAT_LAST  = NB_LAT'(RD_LATENCY - 1);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(N_PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   addr_q,  addr_d;
  logic [NB_LAT-1:0]    lat_q,   lat_d;
  logic [NB_DATA-1:0]   data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 last_q,  last_d;
  logic                 dbg_q,   dbg_d;
  logic                 done_q,  done_d;
  logic                 busy_q,  busy_d;
  logic [NB_CNT-1:0]    cnt_q,   cnt_d;

  // State and output registers; all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      dbg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      dbg_q   <= dbg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: abort overrides everything, otherwise walk the scan.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    dbg_d   = dbg_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    if (i_abort) begin
      // Abort in IDLE simply blocks a concurrent start; the count is kept.
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        dbg_d   = 1'b0;
        addr_d  = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            addr_d  = '0;
            lat_d   = '0;
            cnt_d   = '0;
            dbg_d   = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          // The address has been stable since WAIT entry; capture once the
          // RAM output register has caught up.
          lat_d = lat_q + NB_LAT'(1);
          if (lat_q == LAT_LAST) begin
            data_d  = i_ram_data;
            valid_d = 1'b1;
            last_d  = (addr_q == ADDR_LAST);
            state_d = ST_HOLD;
            if (i_ram_data > i_umbral) begin
              cnt_d = cnt_q + NB_CNT'(1);
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (strm.i_ready) begin
            valid_d = 1'b0;
            if (addr_q == ADDR_LAST) begin
              last_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + NB_ADDR'(1);
              lat_d   = '0;
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DONE: begin
          // done_q is high for exactly this state's cycle.
          dbg_d   = 1'b0;
          addr_d  = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          dbg_d   = 1'b0;
          addr_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign o_ram_dbg    = dbg_q;
  assign o_ram_addr   = addr_q;
  assign strm.o_data  = data_q;
  assign strm.o_valid = valid_q;
  assign strm.o_last  = last_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_above_cnt  = cnt_q;

endmodule

// File: doc/frame_ram_reader.md
# frame_ram_reader

Reads one stored frame out of the speckle sensor controller's pixel RAM through its debug read port and streams it to a downstream consumer over a valid/ready interface. It also counts pixels above a programmable threshold. It sits directly downstream of the controller in the top level. While a scan is active it drives the debug-select bit and address field of the controller's RAM control word, and it samples the controller's RAM output register.

## Interface
Parameters:
- `COLS`, 24, pixel columns per frame
- `ROWS`, 24, pixel rows per frame
- `NB_DATA`, 12, pixel word width
- `RD_LATENCY`, 2, cycles from address change to valid RAM output; legal range 1..15
- Derived: `N_PIX = COLS*ROWS`, `NB_ADDR = $clog2(N_PIX)`, `NB_CNT = $clog2(N_PIX+1)`

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `i_start`  in  1  scan request; sampled only in IDLE
- `i_abort`  in  1  synchronous abort; takes priority over all other inputs except reset
- `i_umbral`  in  NB_DATA  unsigned threshold; sampled at each pixel capture
- `i_ram_data`  in  NB_DATA  controller RAM output register
- `o_ram_dbg`  out  1  debug-port select to controller; high for the whole scan
- `o_ram_addr`  out  NB_ADDR  RAM read address
- `o_data`  out  NB_DATA  captured pixel
- `o_valid`  out  1  `o_data` valid
- `i_ready`  in  1  downstream accepts the beat
- `o_last`  out  1  current beat is pixel N_PIX-1
- `o_busy`  out  1  state is not IDLE
- `o_done`  out  1  one-cycle pulse at scan completion
- `o_above_cnt`  out  NB_CNT  pixels with data > `i_umbral` in the last scan

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Address and latency counters are 0.
- States:
  - **IDLE**
    - `i_start`=1: `o_addr`<=0, lat_cnt<=0, `o_above_cnt`<=0, `o_ram_dbg`<=1, go to WAIT.
  - **WAIT**
    - lat_cnt increments each cycle.
    - When lat_cnt==RD_LATENCY-1: `o_data`<=`i_ram_data`, `o_valid`<=1, `o_last`<=(addr==N_PIX-1), go to HOLD.
    - At the same edge, `o_above_cnt` increments if `i_ram_data` > `i_umbral`. The compare is unsigned.
  - **HOLD**
    - `o_data`, `o_last` and `o_addr` stay stable while `i_ready`=0.
    - `i_ready`=1 and addr<N_PIX-1: `o_valid`<=0, addr<=addr+1, lat_cnt<=0, go to WAIT.
    - `i_ready`=1 and addr==N_PIX-1: `o_valid`<=0, `o_last`<=0, go to DONE.
  - **DONE**
    - `o_done`<=1 for one cycle, `o_ram_dbg`<=0, `o_addr`<=0, go to IDLE.
    - `o_above_cnt` holds until the next accepted `i_start`.
- `i_start` outside IDLE is ignored. It is not queued.
- `i_abort`=1 in any non-IDLE state:
  - Next state is IDLE; `o_valid`, `o_last`, `o_ram_dbg` and `o_addr` go to 0.
  - No `o_done` pulse; `o_above_cnt` keeps its partial value.
  - If `i_abort` and `i_start` are both high in IDLE, abort wins and the scan does not start.
- Reset asserted mid-scan gives reset values immediately; the scan does not resume.
- The address counter does not wrap: the highest address reached is N_PIX-1.

## Timing
- An accepted `i_start` at edge E0 makes `o_ram_dbg`=1 and `o_addr`=0 visible in cycle 1.
- Capture happens at edge E(RD_LATENCY). `o_valid` is first high in cycle RD_LATENCY+1.
- Per-pixel period with `i_ready` held high is RD_LATENCY+1 cycles.
  - Full scan, start edge to `o_done` high: N_PIX*(RD_LATENCY+1)+1 cycles.
  - Defaults: 576*3+1 = 1729 cycles.
- The beat handshake completes on a cycle where `o_valid` and `i_ready` are both high. `i_ready` may toggle freely, and `o_valid` never depends combinationally on `i_ready`.
- `o_ram_addr` changes only on the WAIT-entry edge, so the RAM sees a stable address for at least RD_LATENCY cycles before capture.

## Test plan
All scenarios use COLS=ROWS=4 (N_PIX=16) and RD_LATENCY=2. The bench RAM model returns addr*3 after 2 cycles.
- **Basic scan.** Reset release, `i_start` pulse, `i_ready`=1, `i_umbral`=20.
  - 16 beats with `o_data`=0,3,…,45, `o_last` only on the 45 beat.
  - `o_done` 49 cycles after the start edge, `o_above_cnt`=9.
- **Backpressure.** Same stimulus, `i_ready` pseudo-random at 30% high.
  - Identical data order.
  - `o_data`, `o_last` and `o_addr` stable while `o_valid`=1 and `i_ready`=0.
- **Start ignored while busy.** `i_start` pulses at cycles 5 and 20 during a scan.
  - Exactly one `o_done`.
  - `o_addr` sequence 0..15 with no restart.
- **Abort.** `i_abort` asserted during the 6th beat's HOLD.
  - Next cycle: `o_valid`=0, `o_ram_dbg`=0, `o_busy`=0.
  - No `o_done`; a new `i_start` then yields a full 16-beat scan from address 0.
- **Async reset mid-scan.** `rst` low between clock edges during WAIT.
  - All outputs are 0 before the next edge.
  - After release, the block stays IDLE until `i_start`.
- **Threshold edges.**
  - `i_umbral`=45: `o_above_cnt`=0, because the compare is strict.
  - `i_umbral`=0: `o_above_cnt`=15.
  - `i_umbral`=4095: `o_above_cnt`=0.
